// File: rtl/rom_token_scanner.sv
// rom_token_scanner - walks the expression ROM from index 0 and streams number/operator/end tokens.
// Digits are accumulated into one number; operators and the terminator flush it as a token.
module rom_token_scanner #(
  parameter int DEPTH  = 100,
  parameter int IDX_W  = 7,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [IDX_W-1:0]  rom_index,
  input  logic [7:0]        rom_data,
  output logic              tok_valid,
  input  logic              tok_ready,
  output logic [1:0]        tok_kind,
  output logic [DATA_W-1:0] tok_value,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        err_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EMIT_NUM, S_EMIT_OP, S_EMIT_END, S_DONE, S_ERROR
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DEPTH - 1);
  localparam logic [1:0]       KIND_NUM   = 2'd0;
  localparam logic [1:0]       KIND_OP    = 2'd1;
  localparam logic [1:0]       KIND_END   = 2'd2;
  localparam logic [2:0]       ERR_SYNTAX = 3'd1;
  localparam logic [2:0]       ERR_OVF    = 3'd2;
  localparam logic [2:0]       ERR_NOTERM = 3'd3;
  localparam logic [2:0]       ERR_ILLEG  = 3'd4;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                have_num_q, have_num_d;
  logic [7:0]          op_q, op_d;
  logic                term_q, term_d;
  logic [1:0]          kind_q, kind_d;
  logic [DATA_W-1:0]   value_q, value_d;
  logic [2:0]          err_q, err_d;

  logic                is_digit, is_term, is_op;
  logic [DATA_W+3:0]   acc_wide;
  logic                acc_ovf;

  assign is_digit = (rom_data <= 8'd9);
  assign is_term  = (rom_data == 8'd10);
  assign is_op    = (rom_data >= 8'd20) && (rom_data <= 8'd23);
  // Four guard bits hold acc*10+9 for any DATA_W-bit acc, so overflow is just the top nibble.
  assign acc_wide = (DATA_W+4)'(acc_q) * (DATA_W+4)'(10) + (DATA_W+4)'(rom_data[3:0]);
  assign acc_ovf  = |acc_wide[DATA_W+3:DATA_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      acc_q      <= '0;
      have_num_q <= 1'b0;
      op_q       <= '0;
      term_q     <= 1'b0;
      kind_q     <= '0;
      value_q    <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      have_num_q <= have_num_d;
      op_q       <= op_d;
      term_q     <= term_d;
      kind_q     <= kind_d;
      value_q    <= value_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    have_num_d = have_num_q;
    op_d       = op_q;
    term_d     = term_q;
    kind_d     = kind_q;
    value_d    = value_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        if (start) begin
          state_d    = S_FETCH;
          idx_d      = '0;
          acc_d      = '0;
          have_num_d = 1'b0;
          term_d     = 1'b0;
          err_d      = '0;
        end
      end
      S_FETCH: begin
        if (is_digit) begin
          have_num_d = 1'b1;
          if (acc_ovf) begin
            state_d = S_ERROR;
            err_d   = ERR_OVF;
          end else begin
            acc_d = acc_wide[DATA_W-1:0];
            if (idx_q == LAST_IDX) begin
              state_d = S_ERROR;
              err_d   = ERR_NOTERM;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end else if (is_op || is_term) begin
          if (!have_num_q) begin
            state_d = S_ERROR;
            err_d   = ERR_SYNTAX;
          end else begin
            kind_d  = KIND_NUM;
            value_d = acc_q;
            op_d    = rom_data;
            term_d  = is_term;
            state_d = S_EMIT_NUM;
          end
        end else begin
          state_d = S_ERROR;
          err_d   = ERR_ILLEG;
        end
      end
      S_EMIT_NUM: begin
        if (tok_ready) begin
          acc_d      = '0;
          have_num_d = 1'b0;
          if (term_q) begin
            kind_d  = KIND_END;
            value_d = '0;
            state_d = S_EMIT_END;
          end else begin
            kind_d  = KIND_OP;
            value_d = DATA_W'(op_q);
            state_d = S_EMIT_OP;
          end
        end
      end
      S_EMIT_OP: begin
        if (tok_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_ERROR;
            err_d   = ERR_NOTERM;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_EMIT_END: begin
        if (tok_ready) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tok_valid = (state_q == S_EMIT_NUM) || (state_q == S_EMIT_OP) || (state_q == S_EMIT_END);
    busy      = (state_q == S_FETCH) || tok_valid;
    done      = (state_q == S_DONE);
    error     = (state_q == S_ERROR);
    rom_index = idx_q;
    tok_kind  = kind_q;
    tok_value = value_q;
    err_code  = err_q;
  end

endmodule

// File: tb/tb_rom_token_scanner.sv
// tb/tb_rom_token_scanner.sv - randomized and directed scans checked against a token-list model.
module tb_rom_token_scanner;
  localparam int DEPTH  = 8;
  localparam int IDX_W  = 7;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              tok_ready = 1'b0;
  logic [IDX_W-1:0]  rom_index;
  logic [7:0]        rom_data;
  logic              tok_valid;
  logic [1:0]        tok_kind;
  logic [DATA_W-1:0] tok_value;
  logic              busy, done, error;
  logic [2:0]        err_code;

  logic [7:0] rom [DEPTH];
  assign rom_data = rom[rom_index[2:0]];

  always #5 clk = ~clk;

  rom_token_scanner #(.DEPTH(DEPTH), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .rom_index(rom_index), .rom_data(rom_data),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_kind(tok_kind), .tok_value(tok_value),
    .busy(busy), .done(done), .error(error), .err_code(err_code)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  int exp_kind[$];
  int exp_val[$];
  int exp_err;

  // Tokenize the ROM contents directly from the code map.
  task automatic build_model();
    int acc;
    bit have;
    int c;
    acc = 0;
    have = 0;
    exp_kind.delete();
    exp_val.delete();
    exp_err = 3;
    for (int i = 0; i < DEPTH; i++) begin
      c = int'(rom[i]);
      if (c <= 9) begin
        acc = acc * 10 + c;
        have = 1;
        if (acc > 65535) begin exp_err = 2; break; end
      end else if (c == 10) begin
        if (!have) begin exp_err = 1; break; end
        exp_kind.push_back(0); exp_val.push_back(acc);
        exp_kind.push_back(2); exp_val.push_back(0);
        exp_err = 0;
        break;
      end else if (c >= 20 && c <= 23) begin
        if (!have) begin exp_err = 1; break; end
        exp_kind.push_back(0); exp_val.push_back(acc);
        exp_kind.push_back(1); exp_val.push_back(c);
        acc = 0;
        have = 0;
      end else begin
        exp_err = 4;
        break;
      end
    end
  endtask

  task automatic set_rom(input logic [63:0] p);
    for (int i = 0; i < DEPTH; i++) rom[i] = p[63-8*i -: 8];
  endtask

  // mode 0: ready always high, 1: ready one cycle in three, 2: random ready
  task automatic run_scan(input int mode);
    int got;
    bit fin, stall, end_xfer, r;
    logic [1:0] pk;
    logic [DATA_W-1:0] pv;
    build_model();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    got = 0; fin = 0; stall = 0; end_xfer = 0; pk = '0; pv = '0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (int'(rom_index) >= DEPTH) check("rom_index_range", rom_index, DEPTH - 1);
      if (stall) begin
        check("stall_valid", tok_valid, 1);
        check("stall_kind", tok_kind, pk);
        check("stall_value", tok_value, pv);
      end
      if (end_xfer) check("done_after_end", done, 1);
      if (error) begin
        check("err_code", err_code, exp_err);
        check("err_token_count", got, exp_kind.size());
        check("err_busy", busy, 0);
        check("err_valid", tok_valid, 0);
        fin = 1;
      end else if (done) begin
        check("done_err_code", err_code, exp_err);
        check("done_token_count", got, exp_kind.size());
        fin = 1;
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_busy", busy, 0);
      end else begin
        case (mode)
          0:       r = 1;
          1:       r = (cyc % 3 == 2);
          default: r = 1'($urandom_range(0, 1));
        endcase
        tok_ready = r;
        end_xfer = 0;
        if (tok_valid && r) begin
          if (got < exp_kind.size()) begin
            check("tok_kind", tok_kind, exp_kind[got]);
            check("tok_value", tok_value, exp_val[got]);
          end else begin
            check("extra_token", 1, 0);
          end
          end_xfer = (tok_kind == 2'd2);
          got++;
        end
        stall = tok_valid && !r;
        pk = tok_kind;
        pv = tok_value;
        @(negedge clk);
      end
    end
    if (!fin) check("scan_timeout", 0, 1);
    tok_ready = 1'b0;
  endtask

  localparam logic [63:0] ROM_MAIN = {8'd1, 8'd5, 8'd21, 8'd1, 8'd0, 8'd20, 8'd9, 8'd10};

  initial begin
    bit seen;
    int roll;
    #1 rst = 1'b1;
    #2;
    check("rst_valid", tok_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_err_code", err_code, 0);
    check("rst_index", rom_index, 0);
    check("rst_kind", tok_kind, 0);
    check("rst_value", tok_value, 0);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;

    set_rom(ROM_MAIN);                                               run_scan(0);
    run_scan(1);
    set_rom({8'd6, 8'd5, 8'd5, 8'd3, 8'd6, 8'd10, 8'd255, 8'd255});  run_scan(0);
    set_rom({8'd6, 8'd5, 8'd5, 8'd3, 8'd5, 8'd10, 8'd255, 8'd255});  run_scan(0);
    set_rom({8'd20, 8'd3, 8'd10, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255}); run_scan(0);
    set_rom({8'd3, 8'd20, 8'd10, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255}); run_scan(1);
    set_rom({8'd3, 8'd15, 8'd10, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255}); run_scan(0);
    set_rom({8'd10, 8'd1, 8'd10, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255}); run_scan(0);
    set_rom({8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1});       run_scan(0);
    set_rom({8'd1, 8'd20, 8'd1, 8'd20, 8'd1, 8'd20, 8'd1, 8'd20});   run_scan(2);

    // Reset while an operator token is stalled, then rescan.
    set_rom(ROM_MAIN);
    @(negedge clk); start = 1'b1; tok_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 0;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      if (tok_valid && tok_kind == 2'd1) begin
        seen = 1;
        tok_ready = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    check("op_stall_reached", seen, 1);
    @(negedge clk);
    @(negedge clk);
    check("stall_before_rst", tok_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_valid", tok_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_error", error, 0);
    check("rst_mid_index", rom_index, 0);
    @(negedge clk) rst = 1'b0;
    run_scan(0);

    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < DEPTH; i++) begin
        roll = int'($urandom_range(0, 99));
        if (roll < 60)      rom[i] = 8'($urandom_range(0, 9));
        else if (roll < 75) rom[i] = 8'(20 + $urandom_range(0, 3));
        else if (roll < 93) rom[i] = 8'd10;
        else                rom[i] = 8'(11 + $urandom_range(0, 8));
      end
      run_scan(n % 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
